// File: rtl/ball_engine.sv
// ball_engine: owns the pong ball (position, direction, wall/paddle bounce and
// miss decisions) and redraws it once per frame tick by erasing the old square,
// moving it, then drawing the new square one pixel per cycle on the VGA bus.
// Optional build macro: BALL_SCORE_EN adds a saturating paddle-hit counter on
// the score output; without it score is constant zero.
module ball_engine #(
  parameter int         SCREEN_W    = 160,
  parameter int         SCREEN_H    = 120,
  parameter int         BALL_SIZE   = 2,
  parameter int         PADDLE_W    = 16,
  parameter int         BALL_X0     = 80,
  parameter int         BALL_Y0     = 20,
  parameter logic [2:0] BALL_COLOUR = 3'b111
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       enable,
  input  logic       tick,
  input  logic [7:0] paddle_x,
  input  logic [6:0] paddle_y,
  output logic [7:0] x_out,
  output logic [6:0] y_out,
  output logic [2:0] colour_out,
  output logic       plot,
  output logic       busy,
  output logic       hit,
  output logic       miss,
  output logic [7:0] score
);

  // Pixel counter width; a 1x1 ball still gets a 1-bit counter.
  localparam int            CW    = (BALL_SIZE > 1) ? $clog2(BALL_SIZE) : 1;
  localparam logic [CW-1:0] LAST  = CW'(BALL_SIZE - 1);
  localparam logic [8:0]    SIZE9 = 9'(BALL_SIZE);
  localparam logic [8:0]    W9    = 9'(SCREEN_W);
  localparam logic [8:0]    H9    = 9'(SCREEN_H);
  localparam logic [8:0]    PW9   = 9'(PADDLE_W);
  localparam logic [7:0]    X0    = 8'(BALL_X0);
  localparam logic [6:0]    Y0    = 7'(BALL_Y0);

  typedef enum logic [1:0] {S_WAIT, S_ERASE, S_MOVE, S_DRAW} state_t;

  state_t        state_q;
  logic [7:0]    ball_x_q, ball_x_d;
  logic [6:0]    ball_y_q, ball_y_d;
  logic          dx_neg_q, dx_neg_d;
  logic          dy_neg_q, dy_neg_d;
  logic [CW-1:0] col_q, row_q;
  logic          hit_q, miss_q;
  logic          hit_d, miss_d;
  logic          pix_last;
  logic [8:0]    bx9, by9, px9, py9;

  assign pix_last = (col_q == LAST) && (row_q == LAST);

  // Next ball position/direction; comparisons widened to 9 bits so edge tests never wrap.
  always_comb begin
    bx9      = {1'b0, ball_x_q};
    by9      = {2'b00, ball_y_q};
    px9      = {1'b0, paddle_x};
    py9      = {2'b00, paddle_y};
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dx_neg_d = dx_neg_q;
    dy_neg_d = dy_neg_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;

    if (!dx_neg_q && (bx9 + SIZE9 >= W9)) begin
      dx_neg_d = 1'b1;
      ball_x_d = ball_x_q - 8'd1;
    end else if (dx_neg_q && (ball_x_q == 8'd0)) begin
      dx_neg_d = 1'b0;
      ball_x_d = 8'd1;
    end else if (dx_neg_q) begin
      ball_x_d = ball_x_q - 8'd1;
    end else begin
      ball_x_d = ball_x_q + 8'd1;
    end

    if (dy_neg_q && (ball_y_q == 7'd0)) begin
      dy_neg_d = 1'b0;
      ball_y_d = 7'd1;
    end else if (!dy_neg_q && (by9 + SIZE9 == py9) && (bx9 + SIZE9 > px9) && (bx9 < px9 + PW9)) begin
      dy_neg_d = 1'b1;
      ball_y_d = ball_y_q - 7'd1;
      hit_d    = 1'b1;
    end else if (!dy_neg_q && (by9 + SIZE9 >= H9)) begin
      // Respawn: the horizontal result of this frame is thrown away, dx is kept.
      miss_d   = 1'b1;
      ball_x_d = X0;
      ball_y_d = Y0;
      dx_neg_d = dx_neg_q;
      dy_neg_d = 1'b0;
    end else if (dy_neg_q) begin
      ball_y_d = ball_y_q - 7'd1;
    end else begin
      ball_y_d = ball_y_q + 7'd1;
    end
  end

  // Frame sequencer: WAIT -> ERASE (pixels) -> MOVE -> DRAW (pixels) -> WAIT.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_WAIT;
      ball_x_q <= X0;
      ball_y_q <= Y0;
      dx_neg_q <= 1'b0;
      dy_neg_q <= 1'b0;
      col_q    <= '0;
      row_q    <= '0;
      hit_q    <= 1'b0;
      miss_q   <= 1'b0;
    end else begin
      hit_q  <= 1'b0;
      miss_q <= 1'b0;
      case (state_q)
        S_WAIT: begin
          col_q <= '0;
          row_q <= '0;
          if (tick && enable) state_q <= S_ERASE;
        end
        S_ERASE, S_DRAW: begin
          if (col_q == LAST) begin
            col_q <= '0;
            row_q <= row_q + 1'b1;
          end else begin
            col_q <= col_q + 1'b1;
          end
          if (pix_last) begin
            col_q   <= '0;
            row_q   <= '0;
            state_q <= (state_q == S_ERASE) ? S_MOVE : S_WAIT;
          end
        end
        S_MOVE: begin
          ball_x_q <= ball_x_d;
          ball_y_q <= ball_y_d;
          dx_neg_q <= dx_neg_d;
          dy_neg_q <= dy_neg_d;
          hit_q    <= hit_d;
          miss_q   <= miss_d;
          state_q  <= S_DRAW;
        end
        default: state_q <= S_WAIT;
      endcase
    end
  end

  // Pixel bus decoded from state and pixel counter; idle bus is all zeros.
  always_comb begin
    plot       = 1'b0;
    x_out      = 8'd0;
    y_out      = 7'd0;
    colour_out = 3'b000;
    if ((state_q == S_ERASE) || (state_q == S_DRAW)) begin
      plot       = 1'b1;
      x_out      = ball_x_q + 8'(col_q);
      y_out      = ball_y_q + 7'(row_q);
      colour_out = (state_q == S_DRAW) ? BALL_COLOUR : 3'b000;
    end
  end

  assign busy = (state_q != S_WAIT);
  assign hit  = hit_q;
  assign miss = miss_q;

`ifdef BALL_SCORE_EN
  logic [7:0] score_q;

  // Paddle-hit counter, saturating; only reset clears it.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      score_q <= 8'd0;
    end else if ((state_q == S_MOVE) && hit_d && (score_q != 8'hFF)) begin
      score_q <= score_q + 8'd1;
    end
  end

  assign score = score_q;
`else
  assign score = 8'd0;
`endif

endmodule
